// File: rtl/icache_pkg.sv
// Shared instruction-cache definitions: geometry macros, controller state enum
// and address-field extraction helpers (also used by the data cache).
`ifndef ICACHE_CFG_DEFINED
`define ICACHE_CFG_DEFINED
`define ITAGMSB      31
`define ITAGLSB      10
`define ICACHE_INDEX 6
`define ICACHE_SIZE  64
`endif

package icache_pkg;

  localparam int ITAG_W  = `ITAGMSB - `ITAGLSB + 1;
  localparam int IIDX_W  = `ICACHE_INDEX;
  localparam int ISIZE   = `ICACHE_SIZE;
  // Word-offset bits sit between the byte lane and the index field.
  localparam int ILOFF_W = `ITAGLSB - `ICACHE_INDEX - 2;

  typedef enum logic [2:0] {
    ST_FLUSH,
    ST_LOOKUP,
    ST_REQ,
    ST_FILL,
    ST_COMMIT
  } icache_state_t;

  function automatic logic [ITAG_W-1:0] addr_tag(input logic [`ITAGMSB:0] a);
    return a[`ITAGMSB:`ITAGLSB];
  endfunction

  function automatic logic [IIDX_W-1:0] addr_index(input logic [`ITAGMSB:0] a);
    return a[`ITAGLSB-1 -: `ICACHE_INDEX];
  endfunction

  function automatic logic [ILOFF_W-1:0] addr_off(input logic [`ITAGMSB:0] a);
    return a[ILOFF_W+1:2];
  endfunction

endpackage

// File: rtl/icache_fill_ctr.sv
// Line-refill beat counter with last-beat flag. One bit wider than the offset
// so a single-word line never wraps back to zero before the last beat.
module icache_fill_ctr #(
  parameter int BEATS = 4,
  parameter int CNT_W = $clog2(BEATS) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             last
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign last = (cnt_q == CNT_W'(BEATS - 1));

endmodule

// File: rtl/icache_ctrl.sv
// Direct-mapped I-cache sequencer: lookup, line-fill burst, tag commit and
// full invalidate sweep after reset or on flush.
module icache_ctrl
  import icache_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int LINE_WORDS = 4,
  parameter int OFF_W      = $clog2(LINE_WORDS)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cpu_req,
  input  logic [ADDR_W-1:0]            cpu_addr,
  output logic                         cpu_hit,
  output logic                         cpu_stall,
  input  logic                         flush,
  output logic                         tag_we,
  output logic [`ICACHE_INDEX-1:0]     tag_index,
  output logic                         tag_valid_in,
  output logic [`ITAGMSB-`ITAGLSB:0]   tag_in,
  input  logic                         tag_valid_out,
  input  logic [`ITAGMSB-`ITAGLSB:0]   tag_out,
  output logic                         dram_we,
  output logic [`ICACHE_INDEX-1:0]     dram_index,
  output logic [OFF_W-1:0]             dram_off,
  output logic [31:0]                  dram_wdata,
  output logic                         mem_req,
  output logic [ADDR_W-1:0]            mem_addr,
  input  logic                         mem_gnt,
  input  logic                         mem_rvalid,
  input  logic [31:0]                  mem_rdata
);

  icache_state_t      state_q, state_d;
  logic [IIDX_W-1:0]  fcnt_q, fcnt_d;
  logic               pend_q, pend_d;
  logic [ITAG_W-1:0]  lat_tag_q, lat_tag_d;
  logic [IIDX_W-1:0]  lat_idx_q, lat_idx_d;

  logic [ITAG_W-1:0]  req_tag;
  logic [IIDX_W-1:0]  req_idx;
  logic [OFF_W-1:0]   req_off;
  logic               beat_clr;
  logic               beat_inc;
  logic [OFF_W:0]     beat_cnt;
  logic               beat_last;

  assign req_tag = addr_tag(cpu_addr[`ITAGMSB:0]);
  assign req_idx = addr_index(cpu_addr[`ITAGMSB:0]);
  assign req_off = OFF_W'(addr_off(cpu_addr[`ITAGMSB:0]));

  icache_fill_ctr #(
    .BEATS (LINE_WORDS),
    .CNT_W (OFF_W + 1)
  ) u_fill_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (beat_clr),
    .inc   (beat_inc),
    .cnt   (beat_cnt),
    .last  (beat_last)
  );

  always_comb begin
    state_d      = state_q;
    fcnt_d       = fcnt_q;
    pend_d       = pend_q | (flush & (state_q != ST_FLUSH));
    lat_tag_d    = lat_tag_q;
    lat_idx_d    = lat_idx_q;
    cpu_hit      = 1'b0;
    tag_we       = 1'b0;
    tag_index    = req_idx;
    tag_valid_in = 1'b0;
    tag_in       = '0;
    dram_we      = 1'b0;
    dram_index   = req_idx;
    dram_off     = req_off;
    dram_wdata   = '0;
    mem_req      = 1'b0;
    mem_addr     = '0;
    beat_clr     = 1'b0;
    beat_inc     = 1'b0;

    case (state_q)
      ST_FLUSH: begin
        // Reset holds the state in FLUSH; keep the write strobe quiet until release.
        tag_we    = rst_n;
        tag_index = fcnt_q;
        if (fcnt_q == IIDX_W'(ISIZE - 1)) begin
          fcnt_d  = '0;
          state_d = ST_LOOKUP;
        end else begin
          fcnt_d = fcnt_q + IIDX_W'(1);
        end
      end

      ST_LOOKUP: begin
        if (pend_q) begin
          pend_d  = 1'b0;
          state_d = ST_FLUSH;
        end else if (cpu_req) begin
          if (tag_valid_out && (tag_out == req_tag)) begin
            cpu_hit = 1'b1;
          end else begin
            lat_tag_d = req_tag;
            lat_idx_d = req_idx;
            state_d   = ST_REQ;
          end
        end
      end

      ST_REQ: begin
        mem_req   = 1'b1;
        mem_addr  = ADDR_W'({lat_tag_q, lat_idx_q, {(OFF_W + 2){1'b0}}});
        tag_index = lat_idx_q;
        if (mem_gnt) begin
          beat_clr = 1'b1;
          state_d  = ST_FILL;
        end
      end

      ST_FILL: begin
        tag_index  = lat_idx_q;
        dram_index = lat_idx_q;
        dram_off   = beat_cnt[OFF_W-1:0];
        if (mem_rvalid) begin
          dram_we    = 1'b1;
          dram_wdata = mem_rdata;
          beat_inc   = 1'b1;
          if (beat_last) begin
            state_d = ST_COMMIT;
          end
        end
      end

      ST_COMMIT: begin
        tag_we       = 1'b1;
        tag_valid_in = 1'b1;
        tag_in       = lat_tag_q;
        tag_index    = lat_idx_q;
        if (pend_d) begin
          pend_d  = 1'b0;
          state_d = ST_FLUSH;
        end else begin
          state_d = ST_LOOKUP;
        end
      end

      default: begin
        state_d = ST_FLUSH;
        fcnt_d  = '0;
      end
    endcase
  end

  assign cpu_stall = cpu_req & ~cpu_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_FLUSH;
      fcnt_q    <= '0;
      pend_q    <= 1'b0;
      lat_tag_q <= '0;
      lat_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      fcnt_q    <= fcnt_d;
      pend_q    <= pend_d;
      lat_tag_q <= lat_tag_d;
      lat_idx_q <= lat_idx_d;
    end
  end

endmodule

// File: tb/tb_icache_ctrl.sv
// Directed bench for icache_ctrl with a tag-RAM model and a memory responder.
module tb_icache_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req;
  logic [31:0] cpu_addr;
  logic        cpu_hit, cpu_stall;
  logic        flush;
  logic        tag_we;
  logic [5:0]  tag_index;
  logic        tag_valid_in;
  logic [21:0] tag_in;
  logic        tag_valid_out;
  logic [21:0] tag_out;
  logic        dram_we;
  logic [5:0]  dram_index;
  logic [1:0]  dram_off;
  logic [31:0] dram_wdata;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  icache_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cpu_req       (cpu_req),
    .cpu_addr      (cpu_addr),
    .cpu_hit       (cpu_hit),
    .cpu_stall     (cpu_stall),
    .flush         (flush),
    .tag_we        (tag_we),
    .tag_index     (tag_index),
    .tag_valid_in  (tag_valid_in),
    .tag_in        (tag_in),
    .tag_valid_out (tag_valid_out),
    .tag_out       (tag_out),
    .dram_we       (dram_we),
    .dram_index    (dram_index),
    .dram_off      (dram_off),
    .dram_wdata    (dram_wdata),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_gnt       (mem_gnt),
    .mem_rvalid    (mem_rvalid),
    .mem_rdata     (mem_rdata)
  );

  // Tag RAM: preloaded with valid entries matching 0x1000's tag while in reset,
  // so a missing invalidate sweep shows up as a false hit.
  logic [21:0] tmem [0:63];
  logic        vmem [0:63];
  assign tag_valid_out = vmem[tag_index];
  assign tag_out       = tmem[tag_index];

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 64; i++) begin
        vmem[i] <= 1'b1;
        tmem[i] <= 22'd4;
      end
    end else if (tag_we) begin
      vmem[tag_index] <= tag_valid_in;
      tmem[tag_index] <= tag_in;
    end
  end

  int          n_flw = 0, n_cmt = 0, n_dw = 0, seq_err = 0;
  logic [5:0]  fl_prev = '0;
  logic [31:0] last_maddr = '0;
  logic [1:0]  dw_off [0:255];
  logic [31:0] dw_dat [0:255];

  always @(negedge clk) begin
    if (rst_n) begin
      if (tag_we && !tag_valid_in) begin
        n_flw++;
        if (tag_index != 6'd0 && tag_index != 6'(fl_prev + 6'd1)) seq_err++;
        fl_prev = tag_index;
      end
      if (tag_we && tag_valid_in) n_cmt++;
      if (dram_we) begin
        dw_off[n_dw & 255] = dram_off;
        dw_dat[n_dw & 255] = dram_wdata;
        n_dw++;
      end
      if (mem_req) last_maddr = mem_addr;
    end
  end

  logic hold_gnt = 1'b0;
  int   gnt_delay = 0;
  int   beat_gap = 0;

  initial begin
    int rs, gcnt, rbeat, rgap;
    logic [31:0] rbase;
    rs = 0; gcnt = 0; rbeat = 0; rgap = 0; rbase = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      if (!rst_n) begin
        rs = 0; gcnt = 0;
      end else if (rs == 0) begin
        if (mem_req && !hold_gnt) begin
          if (gcnt >= gnt_delay) begin
            mem_gnt = 1'b1; rbase = mem_addr; rs = 1; rbeat = 0; rgap = 0; gcnt = 0;
          end else begin
            gcnt++;
          end
        end else begin
          gcnt = 0;
        end
      end else begin
        if (rgap >= beat_gap) begin
          mem_rvalid = 1'b1;
          mem_rdata  = (rbase + 32'(4 * rbeat)) ^ 32'hC0DE_0000;
          rbeat++;
          rgap = 0;
          if (rbeat == 4) rs = 0;
        end else begin
          rgap++;
        end
      end
    end
  end

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_hit(input int budget, output int cyc);
    cyc = 0;
    while (!cpu_hit && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic set_addr(input logic [31:0] a);
    @(negedge clk);
    cpu_addr = a;
    #1;
  endtask

  initial begin
    int cyc, f0, c0, d0;
    rst_n = 1'b0; cpu_req = 1'b1; cpu_addr = 32'h1000; flush = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_tag_we", 32'(tag_we), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_cpu_hit", 32'(cpu_hit), 32'd0);
    chk("rst_dram_we", 32'(dram_we), 32'd0);
    chk("rst_stall", 32'(cpu_stall), 32'd1);

    // Cold start: 64-entry sweep, then first miss and fill of 0x1000.
    @(posedge clk); #2 rst_n = 1'b1;
    @(negedge clk);
    chk("flush_first_idx", 32'(tag_index), 32'd0);
    wait_hit(300, cyc);
    chk("cold_latency", 32'(cyc), 32'd71);
    chk("cold_flush_writes", 32'(n_flw), 32'd64);
    chk("cold_commits", 32'(n_cmt), 32'd1);
    chk("cold_dram_writes", 32'(n_dw), 32'd4);
    chk("cold_mem_addr", last_maddr, 32'h1000);
    for (int k = 0; k < 4; k++) begin
      chk("cold_beat_off", 32'(dw_off[k]), 32'(k));
      chk("cold_beat_dat", dw_dat[k], (32'h1000 + 32'(4 * k)) ^ 32'hC0DE_0000);
    end

    // Sequential words of the resident line all hit.
    for (int k = 1; k < 4; k++) begin
      set_addr(32'h1000 + 32'(4 * k));
      chk("seq_hit", 32'(cpu_hit), 32'd1);
      chk("seq_no_mem_req", 32'(mem_req), 32'd0);
      chk("seq_dram_off", 32'(dram_off), 32'(k));
    end

    // Conflict at index 0: tag 5 evicts tag 4, then 0x1000 misses again.
    c0 = n_cmt;
    set_addr(32'h1400);
    chk("conf_miss", 32'(cpu_hit), 32'd0);
    wait_hit(50, cyc);
    chk("conf_latency", 32'(cyc), 32'd7);
    chk("conf_mem_addr", last_maddr, 32'h1400);
    chk("conf_tag", 32'(tmem[0]), 32'd5);
    set_addr(32'h1000);
    chk("refetch_miss", 32'(cpu_hit), 32'd0);
    wait_hit(50, cyc);
    chk("refetch_latency", 32'(cyc), 32'd7);
    chk("conf_commits", 32'(n_cmt - c0), 32'd2);

    // Flush during beat 2: fill finishes, sweep runs, line is refilled.
    f0 = n_flw; c0 = n_cmt; d0 = n_dw;
    set_addr(32'h2050);
    cyc = 0;
    while (!(dram_we && dram_off == 2'd2) && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("flush_saw_beat2", 32'(dram_we && dram_off == 2'd2), 32'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    wait_hit(300, cyc);
    chk("flushfill_hit", 32'(cpu_hit), 32'd1);
    chk("flushfill_sweep", 32'(n_flw - f0), 32'd64);
    chk("flushfill_commits", 32'(n_cmt - c0), 32'd2);
    chk("flushfill_dram", 32'(n_dw - d0), 32'd8);
    chk("flushfill_mem_addr", last_maddr, 32'h2050);

    // Reset while REQ waits for a withheld grant.
    hold_gnt = 1'b1;
    f0 = n_flw; c0 = n_cmt;
    set_addr(32'h3000);
    cyc = 0;
    while (!mem_req && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("req_held", 32'(mem_req), 32'd1);
    cpu_addr = 32'h5550;
    repeat (3) @(negedge clk);
    chk("req_addr_stable", mem_addr, 32'h3000);
    cpu_addr = 32'h3000;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_drops_mem_req", 32'(mem_req), 32'd0);
    @(posedge clk); #2 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_flush_idx0", 32'(tag_index), 32'd0);
    chk("rst_flush_we", 32'(tag_we & ~tag_valid_in), 32'd1);
    repeat (64) @(negedge clk);
    chk("rst_sweep_count", 32'(n_flw - f0), 32'd64);
    chk("rst_no_commit", 32'(n_cmt - c0), 32'd0);
    hold_gnt = 1'b0;
    wait_hit(50, cyc);
    chk("rst_refill_hit", 32'(cpu_hit), 32'd1);
    chk("rst_refill_commit", 32'(n_cmt - c0), 32'd1);

    // Delayed grant and 3-cycle gaps between beats.
    gnt_delay = 2; beat_gap = 3;
    c0 = n_cmt; d0 = n_dw;
    set_addr(32'h4010);
    wait_hit(100, cyc);
    chk("gap_latency", 32'(cyc), 32'd21);
    chk("gap_dram_writes", 32'(n_dw - d0), 32'd4);
    chk("gap_commits", 32'(n_cmt - c0), 32'd1);
    for (int k = 0; k < 4; k++) begin
      chk("gap_beat_off", 32'(dw_off[(d0 + k) & 255]), 32'(k));
      chk("gap_beat_dat", dw_dat[(d0 + k) & 255], (32'h4010 + 32'(4 * k)) ^ 32'hC0DE_0000);
    end
    chk("flush_index_order", 32'(seq_err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/icache_ctrl.md
# icache_ctrl

Sequencing controller for the direct-mapped instruction cache. It owns the write port of `inst_cache_tag` and the instruction data RAM, and turns CPU fetches into hit/miss decisions. On a miss it runs a line-fill burst from memory, then commits tag and valid. It also sweeps all tag entries invalid after reset or on a flush request, and sits between the fetch stage and the instruction memory bus.

## Interface
Parameters:
- `ADDR_W`, 32: byte address width.
- `LINE_WORDS`, 4: 32-bit words per line, power of two ≥1.
- `OFF_W`, $clog2(`LINE_WORDS`): word-offset width.
- Tag and index widths come from `` `ITAGMSB``/`` `ITAGLSB``/`` `ICACHE_INDEX``/`` `ICACHE_SIZE``.
- Address map:
  - tag = addr[`` `ITAGMSB``:`` `ITAGLSB``]
  - index = addr[`` `ITAGLSB``-1 -: `` `ICACHE_INDEX``]
  - offset = addr[`OFF_W`+1:2]

Ports (clock and reset first):
- `clk`  in  1  single clock; all state changes on posedge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `cpu_req`  in  1  fetch request, held until served.
- `cpu_addr`  in  `ADDR_W`  fetch byte address.
- `cpu_hit`  out  1  fetch served this cycle; data RAM read at `dram_index`/`dram_off` is valid.
- `cpu_stall`  out  1  `cpu_req` and not `cpu_hit`.
- `flush`  in  1  one-cycle pulse requesting full invalidate.
- `tag_we`  out  1
- `tag_index`  out  `` `ICACHE_INDEX``
- `tag_valid_in`  out  1
- `tag_in`  out  tag width
- `tag_valid_out`  in  1  from tag RAM, combinational read of `tag_index`.
- `tag_out`  in  tag width  from tag RAM, combinational read of `tag_index`.
- `dram_we`  out  1
- `dram_index`  out  `` `ICACHE_INDEX``
- `dram_off`  out  `OFF_W`
- `dram_wdata`  out  32
- `mem_req`  out  1  line-read request.
- `mem_addr`  out  `ADDR_W`  line-aligned address.
- `mem_gnt`  in  1  request accepted.
- `mem_rvalid`  in  1  one data beat.
- `mem_rdata`  in  32  beat data.

## Operation
States: FLUSH, LOOKUP, REQ, FILL, COMMIT.

FLUSH (entered on reset and from LOOKUP on a pending flush):
- Counter walks 0..`` `ICACHE_SIZE``-1.
- Each cycle: `tag_we`=1, `tag_valid_in`=0, `tag_in`=0, `tag_index`=counter.
- After the last index, go to LOOKUP.
- `cpu_hit`=0 throughout.

LOOKUP:
- `tag_index` = index of `cpu_addr`.
- hit = `cpu_req` & `tag_valid_out` & (`tag_out` == addr tag).
- Hit: `cpu_hit`=1, same cycle; stay in LOOKUP.
- Miss with `cpu_req`: latch tag, index and line base; go to REQ.

REQ:
- `mem_req`=1, `mem_addr` = {tag, index, offset=0, 2'b00}, held stable until `mem_gnt`.
- On `mem_gnt`: beat counter=0, go to FILL.

FILL:
- Each `mem_rvalid`: `dram_we`=1 at latched index, `dram_off`=beat counter, `dram_wdata`=`mem_rdata`; counter increments.
- After beat `LINE_WORDS`-1, go to COMMIT.
- Gaps without `mem_rvalid` are allowed.

COMMIT:
- One cycle: `tag_we`=1, `tag_valid_in`=1, `tag_in`=latched tag, `tag_index`=latched index.
- Next state: FLUSH if a flush is pending, else LOOKUP.

Flush handling:
- A `flush` pulse in any state other than FLUSH sets a pending bit.
- The pending bit is honoured only from LOOKUP or COMMIT, so a fill in progress always completes.
- A `flush` pulse during FLUSH is ignored.

`cpu_addr` changes while stalled are ignored; the fill targets the latched miss address.

## Timing
Reset values: state=FLUSH, counters=0, flush-pending=0. All strobes and `mem_req` are 0; `mem_addr`=0, `cpu_hit`=0.

Latency:
- After reset deassertion, FLUSH takes `` `ICACHE_SIZE`` cycles, then the first lookup.
- Hit: 0 cycles.
- Miss: 1 (LOOKUP) + REQ cycles until `mem_gnt` + `LINE_WORDS` beats + 1 (COMMIT), then a hit in LOOKUP on the following cycle.

Boundary and corner cases:
- `mem_gnt` and first `mem_rvalid` may not arrive in the same cycle; the first beat is at least one cycle after the grant.
- `rst_n` low mid-fill: `mem_req` drops immediately (async), state returns to FLUSH, and the partial line stays invalid.
- Counter wrap: FLUSH counter terminal is `` `ICACHE_SIZE``-1. The beat counter is `OFF_W`+1 bits wide so it does not wrap to 0 early when `LINE_WORDS`=1.

## Structure
- Shared package `icache_pkg`: state enum `icache_state_t` and address-field extraction functions (tag/index/offset) built on the config macros. The data cache reuses these.
- Natural sub-module: `icache_fill_ctr`, the beat counter plus last-beat flag, reused by the data-cache refill path.

## Test plan
- Reset, then hold `cpu_req` at 0x0000_1000: expect 64 FLUSH tag writes (`` `ICACHE_SIZE``=64). Then `mem_req`, `mem_addr`=0x1000, 4 beats written to offsets 0..3, COMMIT writes tag valid, and `cpu_hit`=1 on the next cycle.
- Sequential fetches 0x1000, 0x1004, 0x1008, 0x100C after fill: `cpu_hit`=1 every cycle, `mem_req` stays 0.
- Conflict: after 0x1000 is filled, fetch the address with the same index and a different tag. Expect a miss, refill, and tag overwritten; a re-fetch of 0x1000 misses again.
- `flush` pulse during beat 2 of a fill: the fill completes, COMMIT happens, then a 64-cycle FLUSH, and the next fetch to the same line misses.
- `rst_n` pulse low during REQ while `mem_gnt` is withheld: `mem_req`=0 within the same cycle, FLUSH restarts at index 0, and no COMMIT occurs.
- `mem_rvalid` with 3-cycle gaps between beats: exactly 4 `dram_we` pulses at the correct offsets, and no early COMMIT.
